// File: rtl/intersection_phase_sequencer.sv
// -----------------------------------------------------------------------------
// intersection_phase_sequencer
//
// Steps a four-way intersection through the fixed cycle
//   RED_NS -> NS_GREEN -> NS_YELLOW -> RED_EW -> EW_GREEN -> EW_YELLOW -> RED_NS
// holding each state for exactly its duration in clock cycles, and drives the
// registered lamp outputs for the north-south and east-west heads.
//
// Optional feature macro: EMERGENCY_PREEMPT_EN
//   When defined, 'preempt' cuts a running green short (into its yellow),
//   and diverts the sequencer into PREEMPT_HOLD (all-red) at the end of any
//   all-red clearance for as long as 'preempt' stays high. When undefined,
//   'preempt' is ignored and PREEMPT_HOLD is unreachable.
//
// Parameters:
//   CLK_FREQ        clock frequency in Hz
//   YELLOW_TIME_MS  yellow duration in ms
//   ALL_RED_TIME_MS all-red clearance duration in ms
//
// Ports:
//   clk             single clock, rising edge
//   rst             synchronous, active-high reset
//   ns_green_delay  NS green duration in cycles, sampled at NS green entry
//   ew_green_delay  EW green duration in cycles, sampled at EW green entry
//   preempt         emergency preemption request (macro-dependent)
//   ns_light        NS lamps, one-hot {red, yellow, green}
//   ew_light        EW lamps, one-hot {red, yellow, green}
//   phase           current state encoding
//   phase_start     one-cycle pulse in the first cycle of every state
// -----------------------------------------------------------------------------
module intersection_phase_sequencer #(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int YELLOW_TIME_MS  = 40,
    parameter int ALL_RED_TIME_MS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ns_green_delay,
    input  logic [31:0] ew_green_delay,
    input  logic        preempt,
    output logic [2:0]  ns_light,
    output logic [2:0]  ew_light,
    output logic [2:0]  phase,
    output logic        phase_start
);

    // Durations are computed in 64 bits so the ms*Hz product cannot overflow,
    // then clamped so a state never lasts zero cycles.
    localparam longint YEL_RAW = longint'(YELLOW_TIME_MS) * longint'(CLK_FREQ) / 1000;
    localparam longint RED_RAW = longint'(ALL_RED_TIME_MS) * longint'(CLK_FREQ) / 1000;
    localparam logic [31:0] YEL_CYC = (YEL_RAW < 1) ? 32'd1 : 32'(YEL_RAW);
    localparam logic [31:0] RED_CYC = (RED_RAW < 1) ? 32'd1 : 32'(RED_RAW);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        RED_NS       = 3'd0,
        NS_GREEN     = 3'd1,
        NS_YELLOW    = 3'd2,
        RED_EW       = 3'd3,
        EW_GREEN     = 3'd4,
        EW_YELLOW    = 3'd5,
        PREEMPT_HOLD = 3'd6
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [2:0]  ns_light_reg, ew_light_reg;
    logic [2:0]  ns_light_next, ew_light_next;
    logic        phase_start_reg;
    logic        advance;
    logic        terminal;
    logic        preempt_act;

`ifdef EMERGENCY_PREEMPT_EN
    assign preempt_act = preempt;
`else
    logic unused_preempt;
    assign unused_preempt = preempt;
    assign preempt_act    = 1'b0;
`endif

    assign terminal = (cnt_reg == 32'd0);

    // Next-state selection. No state loops back onto itself, so any change of
    // state is a state entry and reloads the counter.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RED_NS:       if (terminal) state_next = preempt_act ? PREEMPT_HOLD : NS_GREEN;
            NS_GREEN:     if (terminal || preempt_act) state_next = NS_YELLOW;
            NS_YELLOW:    if (terminal) state_next = RED_EW;
            RED_EW:       if (terminal) state_next = preempt_act ? PREEMPT_HOLD : EW_GREEN;
            EW_GREEN:     if (terminal || preempt_act) state_next = EW_YELLOW;
            EW_YELLOW:    if (terminal) state_next = RED_NS;
            PREEMPT_HOLD: if (!preempt_act) state_next = RED_NS;
            default:      state_next = RED_NS;
        endcase
    end

    assign advance = (state_next != state_reg);

    // Counter reload on entry (duration - 1); a green delay of 0 behaves as 1.
    // The green delay is captured here, so later input changes have no effect.
    always_comb begin
        cnt_next = cnt_reg;
        if (advance) begin
            case (state_next)
                RED_NS, RED_EW:       cnt_next = RED_CYC - 32'd1;
                NS_YELLOW, EW_YELLOW: cnt_next = YEL_CYC - 32'd1;
                NS_GREEN:             cnt_next = (ns_green_delay == 32'd0) ? 32'd0 : ns_green_delay - 32'd1;
                EW_GREEN:             cnt_next = (ew_green_delay == 32'd0) ? 32'd0 : ew_green_delay - 32'd1;
                default:              cnt_next = 32'd0;
            endcase
        end else if (!terminal) begin
            cnt_next = cnt_reg - 32'd1;
        end
    end

    // Lamps are decoded from the next state so they switch together with phase.
    always_comb begin
        ns_light_next = LAMP_RED;
        ew_light_next = LAMP_RED;
        case (state_next)
            NS_GREEN:  ns_light_next = LAMP_GREEN;
            NS_YELLOW: ns_light_next = LAMP_YELLOW;
            EW_GREEN:  ew_light_next = LAMP_GREEN;
            EW_YELLOW: ew_light_next = LAMP_YELLOW;
            default: begin
                ns_light_next = LAMP_RED;
                ew_light_next = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RED_NS;
            cnt_reg         <= RED_CYC - 32'd1;
            ns_light_reg    <= LAMP_RED;
            ew_light_reg    <= LAMP_RED;
            phase_start_reg <= 1'b1;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            ns_light_reg    <= ns_light_next;
            ew_light_reg    <= ew_light_next;
            phase_start_reg <= advance;
        end
    end

    assign ns_light    = ns_light_reg;
    assign ew_light    = ew_light_reg;
    assign phase       = state_reg;
    assign phase_start = phase_start_reg;

endmodule

// File: tb/tb_intersection_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_intersection_phase_sequencer
//
// Directed scenarios followed by randomized stimulus, every cycle compared
// against a reference model that tracks the current phase, how long it has
// been shown and how long it is meant to last.
// -----------------------------------------------------------------------------
module tb_intersection_phase_sequencer;

    localparam int CLK_FREQ  = 1000;
    localparam int YEL_MS    = 3;
    localparam int RED_MS    = 2;
    localparam longint YEL_D = 3;
    localparam longint RED_D = 2;

`ifdef EMERGENCY_PREEMPT_EN
    localparam bit PREEMPT_ON = 1'b1;
`else
    localparam bit PREEMPT_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] ns_green_delay;
    logic [31:0] ew_green_delay;
    logic        preempt;
    logic [2:0]  ns_light;
    logic [2:0]  ew_light;
    logic [2:0]  phase;
    logic        phase_start;

    intersection_phase_sequencer #(
        .CLK_FREQ       (CLK_FREQ),
        .YELLOW_TIME_MS (YEL_MS),
        .ALL_RED_TIME_MS(RED_MS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ns_green_delay(ns_green_delay),
        .ew_green_delay(ew_green_delay),
        .preempt       (preempt),
        .ns_light      (ns_light),
        .ew_light      (ew_light),
        .phase         (phase),
        .phase_start   (phase_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors_applied = 0;
    int miscompares     = 0;

    // Reference model state
    int     m_phase   = 0;
    longint m_elapsed = 0;   // cycles already shown in this phase, minus one
    longint m_dur     = RED_D;
    int     cyc       = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_ns(input int ph);
        case (ph)
            1:       return 3'b001;
            2:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_ew(input int ph);
        case (ph)
            4:       return 3'b001;
            5:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Advance the model by one clock edge, given the inputs seen at that edge.
    task automatic model_update(input bit r, input bit p, input logic [31:0] nsd, input logic [31:0] ewd);
        bit adv;
        bit pre;
        int nxt;
        pre = p & PREEMPT_ON;
        if (r) begin
            m_phase = 0; m_elapsed = 0; m_dur = RED_D;
        end else begin
            adv = 1'b0;
            if (m_phase == 6)                                adv = !pre;
            else if (m_elapsed + 1 >= m_dur)                 adv = 1'b1;
            else if (pre && (m_phase == 1 || m_phase == 4))  adv = 1'b1;
            if (adv) begin
                case (m_phase)
                    0:       nxt = pre ? 6 : 1;
                    3:       nxt = pre ? 6 : 4;
                    5, 6:    nxt = 0;
                    default: nxt = m_phase + 1;
                endcase
                m_phase   = nxt;
                m_elapsed = 0;
                case (nxt)
                    0, 3:    m_dur = RED_D;
                    2, 5:    m_dur = YEL_D;
                    1:       m_dur = (nsd == 0) ? 1 : longint'(nsd);
                    4:       m_dur = (ewd == 0) ? 1 : longint'(ewd);
                    default: m_dur = 0;
                endcase
                $display("cycle %0d: phase %0d entered, duration %0d", cyc + 1, nxt, m_dur);
            end else begin
                m_elapsed++;
            end
        end
    endtask

    // One clock cycle: drive inputs, clock, then compare all outputs.
    task automatic step(input bit r, input bit p, input logic [31:0] nsd, input logic [31:0] ewd);
        rst            = r;
        preempt        = p;
        ns_green_delay = nsd;
        ew_green_delay = ewd;
        @(posedge clk);
        #1;
        model_update(r, p, nsd, ewd);
        cyc++;
        check("phase",       32'(phase),       32'(m_phase));
        check("ns_light",    32'(ns_light),    32'(exp_ns(m_phase)));
        check("ew_light",    32'(ew_light),    32'(exp_ew(m_phase)));
        check("phase_start", 32'(phase_start), 32'(m_elapsed == 0));
    endtask

    initial begin
        int pulses;
        bit found;
        logic [31:0] nsd, ewd;
        bit p;

        // Reset, then the 5/7 cycle; count pulses over one 22-cycle period.
        repeat (3) step(1'b1, 1'b0, 32'd5, 32'd7);
        step(1'b0, 1'b0, 32'd5, 32'd7);
        step(1'b0, 1'b0, 32'd5, 32'd7);
        check("ns_green_after_reset", 32'(phase), 32'd1);
        pulses = int'(phase_start);
        for (int i = 0; i < 21; i++) begin
            step(1'b0, 1'b0, 32'd5, 32'd7);
            pulses += int'(phase_start);
        end
        check("pulses_per_cycle", 32'(pulses), 32'd6);

        // NS green entered with 5, delay changes to 9 while it runs.
        step(1'b0, 1'b0, 32'd5, 32'd7);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 32'd9, 32'd7);

        // Preempt for 10 cycles from NS green cycle 2.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_phase == 1 && m_elapsed == 0) found = 1'b1;
            else step(1'b0, 1'b0, 32'd5, 32'd7);
        end
        check("reach_ns_green", 32'(found), 32'd1);
        step(1'b0, 1'b0, 32'd5, 32'd7);
        repeat (10) step(1'b0, 1'b1, 32'd5, 32'd7);
        repeat (30) step(1'b0, 1'b0, 32'd5, 32'd7);

        // One-cycle reset during EW yellow.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_phase == 5) found = 1'b1;
            else step(1'b0, 1'b0, 32'd5, 32'd7);
        end
        check("reach_ew_yellow", 32'(found), 32'd1);
        step(1'b1, 1'b0, 32'd5, 32'd7);
        repeat (25) step(1'b0, 1'b0, 32'd5, 32'd7);

        // Zero EW green delay behaves as one cycle.
        repeat (30) step(1'b0, 1'b0, 32'd4, 32'd0);

        // Randomized stimulus.
        nsd = 32'd5; ewd = 32'd7; p = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7, 0) == 0) nsd = 32'($urandom_range(12, 0));
            if ($urandom_range(7, 0) == 0) ewd = 32'($urandom_range(12, 0));
            if ($urandom_range(19, 0) == 0) p = ~p;
            step($urandom_range(149, 0) == 0, p, nsd, ewd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
